calc_key_frontend: RTL and testbench

Upstream input stage for the RPN stack calculator. It conditions three raw push-buttons (enter, add, multiply) and the 8-bit operand switches, and produces the single-cycle command pulses and operand byte the calculator consumes. The calculator has no ready signal and accepts a command only in its idle state (one command per 3 cycles). This block therefore debounces the buttons, queues presses and enforces a minimum command spacing.

---
 rtl/calc_key_frontend_pkg.sv | 22 ++
 rtl/calc_key_frontend_key_debounce.sv | 53 +++++
 rtl/calc_key_frontend.sv | 146 ++++++++++++++
 tb/tb_calc_key_frontend.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_key_frontend_pkg.sv
// rtl/calc_key_frontend_pkg.sv - shared constants for the calculator key front end
package calc_key_frontend_pkg;

   // Issue FSM encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GAP  = 1'b1;

   // Command index: lower index wins when several presses are pending
   localparam int CMD_ENTER    = 0;
   localparam int CMD_ADD      = 1;
   localparam int CMD_MULTIPLY = 2;
   localparam int NUM_CMDS     = 3;

   // Bits needed for a counter that must hold values 0..max_value
   function automatic int cnt_width(input int max_value);
      if (max_value < 2) begin
         return 1;
      end
      return $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/calc_key_frontend_key_debounce.sv
// rtl/calc_key_frontend_key_debounce.sv - per-key synchronizer, debouncer and press detector
module calc_key_frontend_key_debounce
   import calc_key_frontend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   logic          meta;
   logic          sync;
   logic          stable;
   logic [CW-1:0] count;
   logic          limit;

   // The sample taken at this edge is the last one needed to flip the level
   assign limit = (count == CW'(DEBOUNCE_CYCLES - 1));

   // Press is combinational so the pending bit sets on the very edge stable rises
   assign press = (sync != stable) && limit && !stable;

   // Two-flop synchronizer for the raw button
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // Count consecutive samples that disagree with the debounced level
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= '0;
         stable <= 1'b0;
      end else if (sync == stable) begin
         count <= '0;
      end else if (limit) begin
         count  <= '0;
         stable <= ~stable;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/calc_key_frontend.sv
// rtl/calc_key_frontend.sv - debounced, queued and spaced command pulses for the RPN calculator
module calc_key_frontend
   import calc_key_frontend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_SPACING     = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_enter,
   input  logic       key_add,
   input  logic       key_multiply,
   input  logic [7:0] switches,
   output logic       enter,
   output logic       add,
   output logic       multiply,
   output logic [7:0] data,
   output logic       busy,
   output logic       dropped
);

   localparam int GW = cnt_width(MIN_SPACING);

   logic [NUM_CMDS-1:0] press;
   logic [NUM_CMDS-1:0] pending;
   logic [NUM_CMDS-1:0] pending_next;
   logic [NUM_CMDS-1:0] issue_sel;
   logic [NUM_CMDS-1:0] issue_clr;
   logic [7:0]          sw_meta;
   logic [7:0]          sw_sync;
   logic [0:0]          state;
   logic [GW-1:0]       gap_count;
   logic                can_issue;
   logic                do_issue;
   logic                drop_now;

   calc_key_frontend_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
      .clock (clock),
      .reset (reset),
      .raw   (key_enter),
      .press (press[CMD_ENTER])
   );

   calc_key_frontend_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_add (
      .clock (clock),
      .reset (reset),
      .raw   (key_add),
      .press (press[CMD_ADD])
   );

   calc_key_frontend_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_multiply (
      .clock (clock),
      .reset (reset),
      .raw   (key_multiply),
      .press (press[CMD_MULTIPLY])
   );

   // Idle, or the last gap cycle, lets the next pending command out on this edge
   assign can_issue = (state == ST_IDLE) || (gap_count == '0);
   assign do_issue  = can_issue && (pending != '0);

   // Fixed priority pick: enter, then add, then multiply
   always_comb begin
      issue_sel = '0;
      if (pending[CMD_ENTER]) begin
         issue_sel[CMD_ENTER] = 1'b1;
      end else if (pending[CMD_ADD]) begin
         issue_sel[CMD_ADD] = 1'b1;
      end else if (pending[CMD_MULTIPLY]) begin
         issue_sel[CMD_MULTIPLY] = 1'b1;
      end
   end

   // A fresh press on the edge its bit is issued keeps the bit set
   always_comb begin
      issue_clr    = can_issue ? issue_sel : '0;
      pending_next = (pending & ~issue_clr) | press;
      drop_now     = |(press & pending & ~issue_clr);
   end

   assign busy = (pending != '0) || (state == ST_GAP) || enter || add || multiply;

   // Operand switch synchronizer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
      end
   end

   // Pending presses and the sticky overflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         pending <= pending_next;
         if (drop_now) begin
            dropped <= 1'b1;
         end
      end
   end

   // Registered one-cycle command pulses and operand capture on enter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enter    <= 1'b0;
         add      <= 1'b0;
         multiply <= 1'b0;
         data     <= '0;
      end else begin
         enter    <= issue_clr[CMD_ENTER];
         add      <= issue_clr[CMD_ADD];
         multiply <= issue_clr[CMD_MULTIPLY];
         if (issue_clr[CMD_ENTER]) begin
            data <= sw_sync;
         end
      end
   end

   // Spacing FSM: after a pulse, wait out the gap before the next one
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         gap_count <= '0;
      end else if (do_issue) begin
         if (MIN_SPACING > 1) begin
            state     <= ST_GAP;
            gap_count <= GW'(MIN_SPACING - 1);
         end else begin
            state     <= ST_IDLE;
            gap_count <= '0;
         end
      end else if (state == ST_GAP) begin
         if (gap_count == '0) begin
            state <= ST_IDLE;
         end else begin
            gap_count <= gap_count - GW'(1);
         end
      end
   end

endmodule

// File: tb/tb_calc_key_frontend.sv
// tb/tb_calc_key_frontend.sv - randomized scoreboard bench for calc_key_frontend
module tb_calc_key_frontend;

   localparam int MS = 3;

   typedef struct {
      int         cmd;
      logic [7:0] d;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_enter = 1'b0;
   logic       key_add = 1'b0;
   logic       key_multiply = 1'b0;
   logic [7:0] switches = 8'h00;

   logic       o_enter [2];
   logic       o_add [2];
   logic       o_mult [2];
   logic [7:0] o_data [2];
   logic       o_busy [2];
   logic       o_dropped [2];

   int checks = 0;
   int failures = 0;

   // reference model state, one set per instance; raw history shared
   int         dcyc [2] = '{4, 2};
   bit         khist [3][16];
   logic [7:0] swhist [16];
   bit         stable_m [2][3];
   bit         pend_m [2][3];
   bit         drop_m [2];
   bit         busy_m [2];
   logic [7:0] data_m [2];
   int         last_issue [2];
   int         edge_n = 0;
   exp_t       sbq [2][$];

   calc_key_frontend #(.DEBOUNCE_CYCLES(4), .MIN_SPACING(MS)) dut (
      .clock        (clock),
      .reset        (reset),
      .key_enter    (key_enter),
      .key_add      (key_add),
      .key_multiply (key_multiply),
      .switches     (switches),
      .enter        (o_enter[0]),
      .add          (o_add[0]),
      .multiply     (o_mult[0]),
      .data         (o_data[0]),
      .busy         (o_busy[0]),
      .dropped      (o_dropped[0])
   );

   calc_key_frontend #(.DEBOUNCE_CYCLES(2), .MIN_SPACING(MS)) dut_b (
      .clock        (clock),
      .reset        (reset),
      .key_enter    (key_enter),
      .key_add      (key_add),
      .key_multiply (key_multiply),
      .switches     (switches),
      .enter        (o_enter[1]),
      .add          (o_add[1]),
      .multiply     (o_mult[1]),
      .data         (o_data[1]),
      .busy         (o_busy[1]),
      .dropped      (o_dropped[1])
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string nm, input int n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0t actual=%0d required=%0d", nm, n, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         swhist[i] = 8'h00;
         for (int c = 0; c < 3; c++) khist[c][i] = 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < 3; c++) begin
            stable_m[n][c] = 1'b0;
            pend_m[n][c]   = 1'b0;
         end
         drop_m[n]     = 1'b0;
         busy_m[n]     = 1'b0;
         data_m[n]     = 8'h00;
         last_issue[n] = -100;
         sbq[n].delete();
      end
   endtask

   // Rules: a key level flips after D consecutive synchronized samples
   // (raw delayed by two edges) differ from it; commands leave in priority
   // order no sooner than MS edges after the previous one.
   task automatic model_step();
      bit   clr [3];
      bit   flip;
      bit   press;
      bit   done;
      exp_t e;
      if (reset) return;
      edge_n++;
      for (int i = 15; i > 0; i--) begin
         swhist[i] = swhist[i-1];
         for (int c = 0; c < 3; c++) khist[c][i] = khist[c][i-1];
      end
      swhist[0]   = switches;
      khist[0][0] = key_enter;
      khist[1][0] = key_add;
      khist[2][0] = key_multiply;
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < 3; c++) clr[c] = 1'b0;
         if (edge_n - last_issue[n] >= MS) begin
            done = 1'b0;
            for (int c = 0; c < 3; c++) begin
               if (!done && pend_m[n][c]) begin
                  done   = 1'b1;
                  clr[c] = 1'b1;
                  if (c == 0) data_m[n] = swhist[2];
                  e.cmd = c;
                  e.d   = data_m[n];
                  sbq[n].push_back(e);
                  last_issue[n] = edge_n;
               end
            end
         end
         busy_m[n] = (edge_n - last_issue[n]) < MS;
         for (int c = 0; c < 3; c++) begin
            flip = 1'b1;
            for (int j = 2; j <= dcyc[n] + 1; j++) begin
               if (khist[c][j] == stable_m[n][c]) flip = 1'b0;
            end
            press = flip && !stable_m[n][c];
            if (flip) stable_m[n][c] = !stable_m[n][c];
            if (press && pend_m[n][c] && !clr[c]) drop_m[n] = 1'b1;
            pend_m[n][c] = (pend_m[n][c] && !clr[c]) || press;
            if (pend_m[n][c]) busy_m[n] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_keys(input bit e, input bit a, input bit m);
      key_enter    = e;
      key_add      = a;
      key_multiply = m;
   endtask

   task automatic chk_zero(input string tag);
      for (int n = 0; n < 2; n++) begin
         chk({tag, "_enter"}, n, int'(o_enter[n]), 0);
         chk({tag, "_add"}, n, int'(o_add[n]), 0);
         chk({tag, "_mult"}, n, int'(o_mult[n]), 0);
         chk({tag, "_data"}, n, int'(o_data[n]), 0);
         chk({tag, "_busy"}, n, int'(o_busy[n]), 0);
         chk({tag, "_dropped"}, n, int'(o_dropped[n]), 0);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      model_reset();
      #1;
      chk_zero("rst_now");
      tick();
      reset = 1'b0;
   endtask

   // Monitor: compare every presented pulse against the scoreboard head
   initial begin
      forever begin
         @(negedge clock);
         for (int n = 0; n < 2; n++) begin
            int   np;
            int   cmd;
            exp_t e;
            np = int'(o_enter[n]) + int'(o_add[n]) + int'(o_mult[n]);
            chk("pulses_per_cycle_le1", n, (np > 1) ? np : 1, 1);
            if (np != 0) begin
               cmd = o_enter[n] ? 0 : (o_add[n] ? 1 : 2);
               if (sbq[n].size() == 0) begin
                  chk("unexpected_pulse_cmd", n, cmd, -1);
               end else begin
                  e = sbq[n].pop_front();
                  chk("pulse_cmd", n, cmd, e.cmd);
                  if (cmd == 0) chk("enter_data", n, int'(o_data[n]), int'(e.d));
               end
            end
            chk("busy", n, int'(o_busy[n]), int'(busy_m[n]));
            chk("dropped", n, int'(o_dropped[n]), int'(drop_m[n]));
            chk("data_hold", n, int'(o_data[n]), int'(data_m[n]));
         end
      end
   end

   initial begin
      model_reset();
      // reset with every input high: all outputs stay low
      set_keys(1, 1, 1);
      switches = 8'hFF;
      reset    = 1'b1;
      #1;
      chk_zero("in_reset");
      ticks(4);
      reset = 1'b0;
      ticks(3);
      chk_zero("after_release");
      set_keys(0, 0, 0);
      ticks(40);

      // single enter with operand
      switches = 8'h2A;
      ticks(2);
      set_keys(1, 0, 0);
      ticks(12);
      set_keys(0, 0, 0);
      ticks(14);

      // bouncing add, then a clean hold
      for (int r = 0; r < 5; r++) begin
         set_keys(0, 1, 0);
         ticks(3);
         set_keys(0, 0, 0);
         ticks(1);
      end
      set_keys(0, 1, 0);
      ticks(6);
      set_keys(0, 0, 0);
      ticks(16);

      // simultaneous add and multiply
      set_keys(0, 1, 1);
      ticks(10);
      set_keys(0, 0, 0);
      ticks(20);

      // re-press multiply while still pending
      set_keys(1, 1, 1);
      ticks(3);
      set_keys(1, 1, 0);
      ticks(2);
      set_keys(1, 1, 1);
      ticks(8);
      set_keys(0, 0, 0);
      ticks(24);

      // reset during the gap with multiply pending
      set_keys(0, 1, 1);
      ticks(8);
      set_keys(0, 0, 0);
      pulse_reset();
      ticks(20);

      // randomized key activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) key_enter = ~key_enter;
         if ($urandom_range(0, 4) == 0) key_add = ~key_add;
         if ($urandom_range(0, 3) == 0) key_multiply = ~key_multiply;
         if ($urandom_range(0, 9) == 0) switches = 8'($urandom);
         if ($urandom_range(0, 499) == 0) pulse_reset();
         else tick();
      end
      set_keys(0, 0, 0);
      ticks(40);
      for (int n = 0; n < 2; n++) chk("scoreboard_drained", n, sbq[n].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
